// File: rtl/aes_encrypt_core_if.sv
// Handshake and key-generator bus of the AES-128 encryption core.
// The slave modport is the core side; the master modport is the side that offers
// plaintext, consumes ciphertext and serves round keys.
interface aes_encrypt_core_if #(
    parameter int unsigned BLOCK_LENGTH = 128
);
    logic                    in_valid;
    logic                    in_ready;
    logic [BLOCK_LENGTH-1:0] plaintext;
    logic [BLOCK_LENGTH-1:0] key;
    logic                    out_valid;
    logic                    out_ready;
    logic [BLOCK_LENGTH-1:0] ciphertext;
    logic                    kg_en;
    logic [3:0]              kg_round;
    logic [BLOCK_LENGTH-1:0] kg_key;
    logic [BLOCK_LENGTH-1:0] kg_round_key;
    logic                    kg_key_valid;

    modport slave (
        input  in_valid, plaintext, key, out_ready, kg_round_key, kg_key_valid,
        output in_ready, out_valid, ciphertext, kg_en, kg_round, kg_key
    );

    modport master (
        output in_valid, plaintext, key, out_ready, kg_round_key, kg_key_valid,
        input  in_ready, out_valid, ciphertext, kg_en, kg_round, kg_key
    );
endinterface

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128 encryption core: one round per REQ/APPLY pair, round keys
// fetched from an external key generator. Only BLOCK_LENGTH = 128 is supported.
module aes_encrypt_core #(
    parameter int unsigned BLOCK_LENGTH = 128
) (
    input logic              clk,
    input logic              rst,
    aes_encrypt_core_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StReq, StApply, StDone} state_e;

    // Index 0 is the first entry of the first row.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_e                  state_q;
    logic [3:0]              round_q;
    logic [BLOCK_LENGTH-1:0] blk_q;
    logic [BLOCK_LENGTH-1:0] key_q;
    logic [BLOCK_LENGTH-1:0] ct_q;
    logic                    out_valid_q;
    logic                    kg_en_q;

    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [127:0] sr_flat;
    logic [127:0] mc_flat;
    logic [127:0] round_out;

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.out_valid  = out_valid_q;
    assign bus.ciphertext = ct_q;
    assign bus.kg_en      = kg_en_q;
    assign bus.kg_round   = round_q;
    assign bus.kg_key     = key_q;

    // One full round from the state register and the presented round key.
    // Byte i sits at bits [127-8i -: 8]; byte index = row + 4 * column.
    always_comb begin
        sr_flat = '0;
        mc_flat = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sub_byte(blk_q[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r+4*c] = sb[r+4*((c+r)%4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            sr_flat[127-8*i -: 8] = sr[i];
            mc_flat[127-8*i -: 8] = mc[i];
        end
        if (round_q == 4'd0) begin
            round_out = blk_q ^ bus.kg_round_key;
        end else if (round_q == 4'd10) begin
            round_out = sr_flat ^ bus.kg_round_key;
        end else begin
            round_out = mc_flat ^ bus.kg_round_key;
        end
    end

    // Control FSM with registered outputs; round_q doubles as kg_round and is
    // cleared on leaving the last round so it reads 0 in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            round_q     <= 4'd0;
            blk_q       <= '0;
            key_q       <= '0;
            ct_q        <= '0;
            out_valid_q <= 1'b0;
            kg_en_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        blk_q   <= bus.plaintext;
                        key_q   <= bus.key;
                        round_q <= 4'd0;
                        kg_en_q <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    kg_en_q <= 1'b0;
                    state_q <= StApply;
                end
                StApply: begin
                    if (!bus.kg_key_valid) begin
                        // Key not ready: ask again for the same round.
                        kg_en_q <= 1'b1;
                        state_q <= StReq;
                    end else if (round_q == 4'd10) begin
                        blk_q       <= round_out;
                        ct_q        <= round_out;
                        out_valid_q <= 1'b1;
                        round_q     <= 4'd0;
                        state_q     <= StDone;
                    end else begin
                        blk_q   <= round_out;
                        round_q <= round_q + 4'd1;
                        kg_en_q <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_encrypt_core.sv
// Bench for aes_encrypt_core: a textbook AES-128 model (S-box derived from the
// GF(2^8) inverse, generic matrix MixColumns) feeds a ciphertext scoreboard; a
// reactive key generator serves round keys and can withhold one.
module tb_aes_encrypt_core;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    aes_encrypt_core_if #(.BLOCK_LENGTH(128)) bus ();

    aes_encrypt_core #(.BLOCK_LENGTH(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    logic [7:0]   sb_tab [256];
    logic [127:0] exp_q [$];
    logic [127:0] cur_key = '0;
    int           req_log [$];
    int           withhold_round = -1;
    bit           withheld = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] mix_coef(input int r, input int j);
        int d;
        d = (j - r + 4) % 4;
        return (d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        if (n < 0 || n > 10) return '0;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]], sb_tab[t[31:24]]}
                    ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk;
        logic [127:0] res;
        rk = round_key(k, 0);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        t[r+4*c] = 8'h00;
                        for (int j = 0; j < 4; j++) t[r+4*c] ^= gf_mul(mix_coef(r, j), s[j+4*c]);
                    end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            rk = round_key(k, rnd);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- key generator model ----------------
    // Latches a round key when it sees the one-cycle request; the key stays
    // presented through the following APPLY cycle.
    always @(negedge clk) begin
        if (rst) begin
            bus.kg_key_valid = 1'b0;
            bus.kg_round_key = '0;
        end else if (bus.kg_en) begin
            req_log.push_back(int'(bus.kg_round));
            bus.kg_round_key = round_key(bus.kg_key, int'(bus.kg_round));
            if (int'(bus.kg_round) == withhold_round && !withheld) begin
                bus.kg_key_valid = 1'b0;
                withheld = 1'b1;
            end else begin
                bus.kg_key_valid = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid || bus.kg_en)
                check("busy_not_ready", 128'(bus.in_ready), 128'(0));
            if (bus.in_ready)
                check("idle_round_zero", 128'(bus.kg_round), 128'(0));
            if (bus.kg_en) begin
                check("kg_key_captured", bus.kg_key, cur_key);
                check("kg_round_range", 128'(bus.kg_round > 4'd10), 128'(0));
            end
            if (bus.out_valid) begin
                check("out_valid_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    check("scoreboard_ct", bus.ciphertext, exp_q[0]);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
        check({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, "_kg_en"}, 128'(bus.kg_en), 128'(0));
        check({tag, "_kg_round"}, 128'(bus.kg_round), 128'(0));
        check({tag, "_kg_key"}, bus.kg_key, 128'(0));
        check({tag, "_ciphertext"}, bus.ciphertext, 128'(0));
    endtask

    task automatic accept_block(input logic [127:0] pt, input logic [127:0] k);
        int guard = 0;
        while (!bus.in_ready && guard < 60) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("accept_ready", 128'(bus.in_ready), 128'(1));
        bus.in_valid = 1'b1;
        bus.plaintext = pt;
        bus.key = k;
        @(posedge clk);
        exp_q.push_back(aes_ref(pt, k));
        cur_key = k;
        #1;
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
        bus.key = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic finish_block(input int exp_lat, input int stall, input bit noise,
                                output logic [127:0] ct);
        int lat = 0;
        while (!bus.out_valid && lat < 100) begin
            if (noise && bus.kg_round >= 4'd3 && bus.kg_round <= 4'd7) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
                bus.key = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat = cyc - acc_cyc;
        end
        bus.in_valid = 1'b0;
        check("latency", 128'(lat), 128'(exp_lat));
        ct = bus.ciphertext;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", 128'(bus.out_valid), 128'(1));
            check("stall_ct_stable", bus.ciphertext, ct);
            check("stall_in_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("release_in_ready", 128'(bus.in_ready), 128'(1));
        check("release_out_valid", 128'(bus.out_valid), 128'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct;
        logic [127:0] pt;
        logic [127:0] k;
        int           wh;
        int           g;

        // S-box from multiplicative inverse plus affine map.
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                        ^ 8'h63;
        end

        // Pin the model to published values.
        check("model_sbox_53", 128'(sb_tab[8'h53]), 128'(8'hed));
        check("model_rk10", round_key(K2, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_vec1", aes_ref(PT1, K1), CT1);
        check("model_vec2", aes_ref(PT2, K2), CT2);

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.plaintext = '0;
        bus.key = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", 128'(bus.in_ready), 128'(1));

        // Basic vector.
        accept_block(PT1, K1);
        finish_block(22, 0, 1'b0, ct);
        check("vec1_ct", ct, CT1);

        // Round request sequence.
        req_log.delete();
        accept_block(PT2, K2);
        finish_block(22, 0, 1'b0, ct);
        check("vec2_ct", ct, CT2);
        check("vec2_req_count", 128'(req_log.size()), 128'(11));
        for (int i = 0; i < req_log.size(); i++)
            check("vec2_req_round", 128'(req_log[i]), 128'(i));

        // Back-pressure on the output.
        accept_block(PT1, K1);
        finish_block(22, 5, 1'b0, ct);
        check("stall_ct", ct, CT1);

        // Input noise while busy.
        accept_block(PT1, K1);
        finish_block(22, 0, 1'b1, ct);
        check("noise_ct", ct, CT1);

        // Reset in the middle of round 5.
        accept_block(PT2, K2);
        g = 0;
        while (!(bus.kg_en && bus.kg_round == 4'd5) && g < 60) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("reached_round5", 128'(bus.kg_round), 128'(5));
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("midreset_no_valid", 128'(bus.out_valid), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("after_abort_idle", 128'(bus.in_ready), 128'(1));
        req_log.delete();
        accept_block(PT2, K2);
        finish_block(22, 0, 1'b0, ct);
        check("after_abort_ct", ct, CT2);
        check("after_abort_reqs", 128'(req_log.size()), 128'(11));

        // Key withheld once at round 4.
        withhold_round = 4;
        withheld = 1'b0;
        req_log.delete();
        accept_block(PT1, K1);
        finish_block(24, 0, 1'b0, ct);
        check("withhold_ct", ct, CT1);
        check("withhold_reqs", 128'(req_log.size()), 128'(12));
        withhold_round = -1;

        // Random blocks, random stalls, optional key withhold.
        for (int n = 0; n < 8; n++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            wh = int'($urandom_range(0, 14));
            if (wh > 10) wh = -1;
            withhold_round = wh;
            withheld = 1'b0;
            accept_block(pt, k);
            finish_block((wh >= 0) ? 24 : 22, int'($urandom_range(0, 3)), 1'b0, ct);
            check("random_ct", ct, aes_ref(pt, k));
        end
        withhold_round = -1;

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_encrypt_core.md
AES_ENCRYPT_CORE -- requirements
Module: aes_encrypt_core

Interface
REQ-001 SHALL have parameter BLOCK_LENGTH, default 128, data/key width; only 128 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  plaintext/key offered.
REQ-005 SHALL have port in_ready  output  1  core idle, will accept.
REQ-006 SHALL have port plaintext  input  128  input block, byte 0 = bits [127:120], column-major state.
REQ-007 SHALL have port key  input  128  cipher key K0, same byte order.
REQ-008 SHALL have port out_valid  output  1  ciphertext available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts ciphertext.
REQ-010 SHALL have port ciphertext  output  128  result block.
REQ-011 SHALL have port kg_en  output  1  drives key generator en.
REQ-012 SHALL have port kg_round  output  4  drives key generator Round_Count.
REQ-013 SHALL have port kg_key  output  128  drives key generator key input (captured K0).
REQ-014 SHALL have port kg_round_key  input  128  key generator current_key.
REQ-015 SHALL have port kg_key_valid  input  1  key generator key_valid.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, APPLY, DONE; in_ready = (state==IDLE), combinational.
REQ-017 IDLE: on in_valid&in_ready SHALL register plaintext into state reg, key into kg_key, round counter r=0, go REQ.
REQ-018 REQ: SHALL assert kg_en=1, kg_round=r for exactly one cycle, go APPLY; kg_en SHALL be 0 in all other states.
REQ-019 APPLY with kg_key_valid=1: r=0 -> state ^= kg_round_key; r=1..9 -> SubBytes, ShiftRows, MixColumns, AddRoundKey; r=10 -> SubBytes, ShiftRows, AddRoundKey (no MixColumns).
REQ-020 APPLY with kg_key_valid=0: SHALL leave state and r unchanged and return to REQ (re-request same round).
REQ-021 After APPLY of r<10 SHALL increment r and go REQ; after r=10 SHALL load ciphertext from result and go DONE.
REQ-022 Latency: accept at cycle T0 -> out_valid=1 at T22 (11 rounds x 2 cycles) with a compliant key generator.
REQ-023 DONE: out_valid=1, ciphertext stable until out_valid&out_ready; then IDLE (in_ready=1 next cycle).
REQ-024 in_valid while not IDLE SHALL be ignored; plaintext/key changes after acceptance SHALL not affect result.
REQ-025 Round datapath SHALL be combinational from state reg and kg_round_key, registered once per APPLY; 16 S-box lookups in parallel using the codebase's AES S-box; MixColumns via xtime over GF(2^8), poly 0x11B.
REQ-026 kg_round SHALL hold r in REQ/APPLY and 0 in IDLE/DONE; r SHALL never exceed 10.

Reset
REQ-027 rst=1 SHALL asynchronously force: state IDLE, r=0, state reg=0, kg_key=0, ciphertext=0, out_valid=0, kg_en=0, kg_round=0; in_ready=1 while in IDLE after release.
REQ-028 rst mid-operation SHALL abort the block with no out_valid pulse; next accepted block SHALL compute correctly.

Verification
REQ-029 key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at T22.
REQ-030 key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; kg_round sequence 0..10, each one kg_en pulse.
REQ-031 out_ready held 0 for 5 cycles after out_valid -> ciphertext and out_valid stable 5 cycles, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-032 in_valid toggled with new pt/key during rounds 3..7 -> ignored, result still per REQ-029.
REQ-033 rst pulsed at round 5 -> all outputs at reset values within same cycle, no out_valid; REQ-030 vector then passes.
REQ-034 key generator model withholding kg_key_valid once at round 4 -> extra REQ for round 4, result unchanged, out_valid at T24.
